// File: rtl/full_adder_checker.sv
// Built-in self-test controller for a 1-bit full adder: walks all eight {A,B,cin}
// vectors, holds each for SETTLE cycles, samples sum/carry and records failures.
module full_adder_checker #(
    parameter int SETTLE = 2  // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_start,
    output logic       dout_A,
    output logic       dout_B,
    output logic       dout_cin,
    input  logic       din_sum,
    input  logic       din_carry,
    output logic       dout_busy,
    output logic       dout_done,
    output logic       dout_pass,
    output logic [3:0] dout_err_count,
    output logic       dout_fail_valid,
    output logic [2:0] dout_fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    function automatic logic fa_sum(input logic [2:0] v);
        return v[2] ^ v[1] ^ v[0];
    endfunction

    function automatic logic fa_carry(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic       fail_valid_q, fail_valid_d;
    logic [2:0] fail_vec_q, fail_vec_d;
    logic [2:0] vec_q, vec_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       miss_s;

    // Next-state logic; outputs are derived from the next state so they register with it
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        miss_s       = (din_sum != fa_sum(idx_q)) || (din_carry != fa_carry(idx_q));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (din_start) begin
                    state_d      = ST_APPLY;
                    idx_d        = 3'd0;
                    cnt_d        = 4'd0;
                    err_d        = 4'd0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = 3'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_APPLY: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_APPLY;
                end
            end
            ST_CHECK: begin
                if (miss_s) begin
                    err_d = err_q + 4'd1;
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = idx_q;
                    end else begin
                        fail_vec_d = fail_vec_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if (idx_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = 4'd0;
                    state_d = ST_APPLY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_APPLY) || (state_d == ST_CHECK);
        vec_d  = busy_d ? idx_d : 3'd0;
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == 4'd0);
    end

    // State and registered outputs; reset clears everything, abandoning any run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            cnt_q        <= 4'd0;
            err_q        <= 4'd0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 3'd0;
            vec_q        <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign dout_A          = vec_q[2];
    assign dout_B          = vec_q[1];
    assign dout_cin        = vec_q[0];
    assign dout_busy       = busy_q;
    assign dout_done       = done_q;
    assign dout_pass       = pass_q;
    assign dout_err_count  = err_q;
    assign dout_fail_valid = fail_valid_q;
    assign dout_fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_full_adder_checker.sv
// Directed bench: one checker with a fault-injectable adder (SETTLE=2) plus two
// checkers with healthy adders at SETTLE=1 and SETTLE=15.
module tb_full_adder_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_m = 1'b0;
    logic start_x = 1'b0;
    logic [1:0] fault = 2'd0;  // 0 healthy, 1 carry stuck at 0, 2 sum inverted

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic a_m, b_m, c_m, sum_m, carry_m, busy_m, done_m, pass_m, fv_m;
    logic [3:0] err_m;
    logic [2:0] fvec_m;
    logic a_1, b_1, c_1, sum_1, carry_1, busy_1, done_1, pass_1, fv_1;
    logic [3:0] err_1;
    logic [2:0] fvec_1;
    logic a_f, b_f, c_f, sum_f, carry_f, busy_f, done_f, pass_f, fv_f;
    logic [3:0] err_f;
    logic [2:0] fvec_f;

    assign sum_m   = (a_m ^ b_m ^ c_m) ^ (fault == 2'd2);
    assign carry_m = (fault == 2'd1) ? 1'b0 : ((a_m & b_m) | (a_m & c_m) | (b_m & c_m));
    assign sum_1   = a_1 ^ b_1 ^ c_1;
    assign carry_1 = (a_1 & b_1) | (a_1 & c_1) | (b_1 & c_1);
    assign sum_f   = a_f ^ b_f ^ c_f;
    assign carry_f = (a_f & b_f) | (a_f & c_f) | (b_f & c_f);

    full_adder_checker #(.SETTLE(2)) u_dut_m (
        .clk(clk), .rst(rst), .din_start(start_m),
        .dout_A(a_m), .dout_B(b_m), .dout_cin(c_m),
        .din_sum(sum_m), .din_carry(carry_m),
        .dout_busy(busy_m), .dout_done(done_m), .dout_pass(pass_m),
        .dout_err_count(err_m), .dout_fail_valid(fv_m), .dout_fail_vec(fvec_m)
    );

    full_adder_checker #(.SETTLE(1)) u_dut_1 (
        .clk(clk), .rst(rst), .din_start(start_x),
        .dout_A(a_1), .dout_B(b_1), .dout_cin(c_1),
        .din_sum(sum_1), .din_carry(carry_1),
        .dout_busy(busy_1), .dout_done(done_1), .dout_pass(pass_1),
        .dout_err_count(err_1), .dout_fail_valid(fv_1), .dout_fail_vec(fvec_1)
    );

    full_adder_checker #(.SETTLE(15)) u_dut_f (
        .clk(clk), .rst(rst), .din_start(start_x),
        .dout_A(a_f), .dout_B(b_f), .dout_cin(c_f),
        .din_sum(sum_f), .din_carry(carry_f),
        .dout_busy(busy_f), .dout_done(done_f), .dout_pass(pass_f),
        .dout_err_count(err_f), .dout_fail_valid(fv_f), .dout_fail_vec(fvec_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done_m();
        int n = 0;
        while (!done_m && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done_m) check("done_timeout", 32'(done_m), 32'd1);
    endtask

    task automatic run_main();
        @(negedge clk) start_m = 1'b1;
        @(negedge clk) start_m = 1'b0;
        wait_done_m();
    endtask

    task automatic check_main(input logic p, input logic [3:0] e, input logic v, input logic [2:0] fv);
        check("done", 32'(done_m), 32'd1);
        check("busy_idle", 32'(busy_m), 32'd0);
        check("pass", 32'(pass_m), 32'(p));
        check("err_count", 32'(err_m), 32'(e));
        check("fail_valid", 32'(fv_m), 32'(v));
        check("fail_vec", 32'(fvec_m), 32'(fv));
        check("vec_idle", 32'({a_m, b_m, c_m}), 32'd0);
    endtask

    initial begin
        int c2, c1, c15, n;

        #1 rst = 1'b1;
        #10;
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_done", 32'(done_m), 32'd0);
        check("rst_pass", 32'(pass_m), 32'd0);
        check("rst_err", 32'(err_m), 32'd0);
        check("rst_vec", 32'({a_m, b_m, c_m}), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Healthy run on all three settle values
        @(negedge clk) begin start_m = 1'b1; start_x = 1'b1; end
        @(negedge clk) begin start_m = 1'b0; start_x = 1'b0; end
        c2 = 0; c1 = 0; c15 = 0;
        for (int k = 0; k < 200; k++) begin
            if (k < 24) check("vec_step", 32'({a_m, b_m, c_m}), 32'(k / 3));
            if (k == 15) check("s1_done_early", 32'(done_1), 32'd0);
            if (k == 16) check("s1_done_at16", 32'(done_1), 32'd1);
            if (k == 23) check("s2_done_early", 32'(done_m), 32'd0);
            if (k == 24) check("s2_done_at24", 32'(done_m), 32'd1);
            if (k == 24) check("s2_pass_at24", 32'(pass_m), 32'd1);
            if (k == 127) check("s15_done_early", 32'(done_f), 32'd0);
            if (k == 128) check("s15_done_at128", 32'(done_f), 32'd1);
            if (busy_m) c2++;
            if (busy_1) c1++;
            if (busy_f) c15++;
            @(negedge clk);
        end
        check("s2_busy_cycles", 32'(c2), 32'd24);
        check("s1_busy_cycles", 32'(c1), 32'd16);
        check("s15_busy_cycles", 32'(c15), 32'd128);
        check_main(1'b1, 4'd0, 1'b0, 3'd0);
        check("s1_pass", 32'({pass_1, err_1, fv_1, fvec_1}), 32'({1'b1, 4'd0, 1'b0, 3'd0}));
        check("s15_pass", 32'({pass_f, err_f, fv_f, fvec_f}), 32'({1'b1, 4'd0, 1'b0, 3'd0}));

        // Carry stuck at 0: vectors 011,101,110,111 fail
        fault = 2'd1;
        run_main();
        check_main(1'b0, 4'd4, 1'b1, 3'd3);

        // Sum inverted: every vector fails
        fault = 2'd2;
        run_main();
        check_main(1'b0, 4'd8, 1'b1, 3'd0);

        // Asynchronous reset while vector 4 is applied
        fault = 2'd1;
        @(negedge clk) start_m = 1'b1;
        @(negedge clk) start_m = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_rst_vec", 32'({a_m, b_m, c_m}), 32'd4);
        check("pre_rst_err", 32'(err_m), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy_m), 32'd0);
        check("arst_vec", 32'({a_m, b_m, c_m}), 32'd0);
        check("arst_err", 32'(err_m), 32'd0);
        check("arst_fail", 32'({fv_m, fvec_m}), 32'd0);
        check("arst_done_pass", 32'({done_m, pass_m}), 32'd0);
        @(negedge clk) begin rst = 1'b0; fault = 2'd0; end
        run_main();
        check_main(1'b1, 4'd0, 1'b0, 3'd0);

        // Start held high: no mid-run restart, next run begins right after done
        @(negedge clk) start_m = 1'b1;
        @(negedge clk);
        n = 0; c2 = 0;
        while (!done_m && n < 100) begin
            if (busy_m) c2++;
            n++;
            @(negedge clk);
        end
        check("held_busy_cycles", 32'(c2), 32'd24);
        check("held_done", 32'(done_m), 32'd1);
        check("held_busy_low", 32'(busy_m), 32'd0);
        @(negedge clk);
        check("restart_busy", 32'(busy_m), 32'd1);
        check("restart_done", 32'(done_m), 32'd0);
        check("restart_pass", 32'(pass_m), 32'd0);
        start_m = 1'b0;
        wait_done_m();
        check_main(1'b1, 4'd0, 1'b0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/full_adder_checker.md
# full_adder_checker

Sequential built-in self-test controller for a 1-bit full adder. On a start request it drives all eight {A, B, cin} input combinations into the adder under test, waits a programmable settle time per vector, and samples the returned sum/carry. It compares each result against the expected value and reports busy/done, an error count, pass/fail, and the first failing vector. It sits beside a full_adder instance as the hardware stimulus-and-response end of the adder interface.

## Interface

Parameters:
- SETTLE, default 2: cycles each vector is held before its result is sampled; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- din_start  input  1  run request, sampled only in IDLE or DONE
- dout_A  output  1  operand A to the adder under test
- dout_B  output  1  operand B to the adder under test
- dout_cin  output  1  carry-in to the adder under test
- din_sum  input  1  sum returned by the adder under test
- din_carry  input  1  carry returned by the adder under test
- dout_busy  output  1  high while a run is in progress
- dout_done  output  1  high from run completion until the next accepted start
- dout_pass  output  1  high with dout_done when dout_err_count == 0
- dout_err_count  output  4  number of failing vectors in the last run, 0..8
- dout_fail_valid  output  1  at least one vector failed in the current or last run
- dout_fail_vec  output  3  index {A,B,cin} of the first failing vector

## Operation

- State machine: IDLE, APPLY, CHECK, DONE.
- Internal registers: 3-bit vector index idx, 4-bit settle counter.
- Vector mapping: {dout_A, dout_B, dout_cin} = idx in APPLY and CHECK. All three are driven 0 in IDLE and DONE.
- IDLE: when din_start = 1, clear err_count, fail_valid, fail_vec, and done; set idx = 0 and settle counter = 0; go to APPLY.
- APPLY: increment the settle counter each cycle. When it reaches SETTLE-1, go to CHECK.
- CHECK: one cycle. On its closing edge, sample din_sum and din_carry.
  - Expected sum = A^B^cin.
  - Expected carry = majority(A, B, cin).
  - On mismatch (either bit), increment err_count. If fail_valid = 0, also set fail_valid = 1 and fail_vec = idx.
  - If idx == 7, go to DONE. Otherwise increment idx, clear the settle counter, and go to APPLY.
- DONE:
  - dout_done = 1, and dout_pass = (err_count == 0).
  - Results hold until din_start = 1, which restarts exactly as from IDLE.
- dout_busy = 1 in APPLY and CHECK only.
- din_start is ignored in APPLY and CHECK.
- err_count saturates naturally at 8 and cannot overflow 4 bits.

## Timing

- Reset (asynchronous, any state, including mid-run): state IDLE, idx 0, settle counter 0, all outputs 0. The run is abandoned with no partial result retained.
- Start acceptance: din_start sampled at edge E0 in IDLE. From E0, busy = 1 and vector 0 is driven.
- Each vector is held for SETTLE+1 cycles: SETTLE cycles in APPLY plus 1 in CHECK.
- Vector k is sampled at edge E0 + (k+1)(SETTLE+1).
- Completion: at edge E0 + 8(SETTLE+1), busy falls and done/pass rise in the same cycle. With SETTLE = 2, this is E0 + 24.
- The adder under test is combinational. Its outputs must settle within SETTLE cycles of a vector change.
- Restart from DONE: done and pass drop at the accepting edge, and busy rises at the same edge.

## Test plan

- Correct adder connected, SETTLE=2, pulse din_start:
  - busy is high for exactly 24 cycles.
  - Vectors step 000..111, one every 3 cycles.
  - done=1, pass=1, err_count=0, fail_valid=0.
- Carry stuck at 0:
  - err_count=4 (vectors 011, 101, 110, 111), pass=0.
  - fail_valid=1, fail_vec=3'b011.
- Sum inverted: err_count=8, fail_vec=3'b000, pass=0.
- Assert rst during vector 4 of a run:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - A subsequent start runs cleanly to pass=1.
- din_start held high throughout a run: no restart mid-run. A second run begins on the cycle after done rises, and done drops.
- SETTLE=1: done at E0+16. SETTLE=15: done at E0+128. Results match the SETTLE=2 case.
